// File: rtl/i2s_sample_packer.sv
// i2s_sample_packer: buffers strobed audio samples in a FIFO and streams them out MSB-first as bytes.
// Optional macro PACKER_HEADER_EN prefixes every sample with a {4'hA, seq[3:0]} header byte.
module i2s_sample_packer #(
    parameter int DATA_SIZE  = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_SIZE-1:0]        audio_data,
    input  logic                        ready,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clear_ovf
);
    localparam int OUT_BYTES = (DATA_SIZE + 7) / 8;
    localparam int DW        = OUT_BYTES * 8;
    localparam int PAD       = DW - DATA_SIZE;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
`ifdef PACKER_HEADER_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int TOTAL_BYTES = OUT_BYTES + HDR_BYTES;
    localparam int SRW         = TOTAL_BYTES * 8;
    localparam int IW          = $clog2(TOTAL_BYTES) + 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(TOTAL_BYTES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [SRW-1:0]       sr_q, sr_d;
    logic [IW-1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic          wr_en, full, do_write, drop, pop, is_last;
    logic [DW-1:0] head_ext;
    logic [SRW-1:0] load_val;

`ifdef PACKER_HEADER_EN
    logic [3:0] seq_q, seq_d;

    always_comb begin
        seq_d = pop ? seq_q + 4'd1 : seq_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) seq_q <= 4'd0;
        else        seq_q <= seq_d;
    end
`endif

    // The head entry is left-justified so the sample MSB leaves first; header sits above it.
    always_comb begin
        head_ext = DW'(mem_q[rd_ptr_q]) << PAD;
`ifdef PACKER_HEADER_EN
        load_val = {4'hA, seq_q, head_ext};
`else
        load_val = head_ext;
`endif
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        byte_idx_d = byte_idx_q;
        pop        = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        is_last    = (byte_idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    sr_d       = load_val;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = sr_q[SRW-1 -: 8];
                out_last  = is_last;
                if (out_ready) begin
                    if (is_last) begin
                        if (count_q != '0) begin
                            pop        = 1'b1;
                            sr_d       = load_val;
                            byte_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sr_d       = sr_q << 8;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a write to a full FIFO only drops without one.
    always_comb begin
        ready_d    = ready;
        wr_en      = ready && !ready_q;
        full       = (count_q == FULL_COUNT);
        do_write   = wr_en && (!full || pop);
        drop       = wr_en && full && !pop;
        wr_ptr_d   = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(do_write) - CW'(pop);
        overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sr_q       <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sr_q       <= sr_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= audio_data;
    end

    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2s_sample_packer.sv
// Directed self-checking bench for i2s_sample_packer; expected byte streams are built from the sample
// values, with header bytes added when PACKER_HEADER_EN is defined.
module tb_i2s_sample_packer;
    localparam int DATA_SIZE  = 24;
    localparam int FIFO_DEPTH = 16;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef PACKER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int SPB = 3 + HDR;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DATA_SIZE-1:0] audio_data;
    logic                 ready;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [CW-1:0]        fifo_count;
    logic                 overflow;
    logic                 clear_ovf;

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_seq = 0;
    int cyc     = 0;

    logic [7:0] mon_data [0:255];
    logic       mon_last [0:255];
    int         mon_cyc  [0:255];
    int         mon_n = 0;

    logic [7:0] exp_q  [$];
    logic       expl_q [$];

    always #5 clk = ~clk;

    i2s_sample_packer #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .audio_data(audio_data), .ready(ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .fifo_count(fifo_count), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted byte; a handshake is only real if reset is not asserted at that edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && mon_n < 256) begin
            mon_data[mon_n] <= out_data;
            mon_last[mon_n] <= out_last;
            mon_cyc[mon_n]  <= cyc;
            mon_n           <= mon_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [23:0] v);
        if (HDR != 0) begin
            exp_q.push_back({4'hA, exp_seq[3:0]});
            expl_q.push_back(1'b0);
        end
        exp_q.push_back(v[23:16]); expl_q.push_back(1'b0);
        exp_q.push_back(v[15:8]);  expl_q.push_back(1'b0);
        exp_q.push_back(v[7:0]);   expl_q.push_back(1'b1);
        exp_seq++;
    endtask

    task automatic wait_bytes(input int base, input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (mon_n - base >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b0; audio_data = '0; out_ready = 1'b0; clear_ovf = 1'b0;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_last: got %b want 0", out_last); end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        rst_n = 1'b1;
        exp_seq = 0;
        step();
    endtask

    task automatic test_single();
        int base;
        bit ok;
        base = mon_n;
        exp_q.delete(); expl_q.delete();
        push_sample(24'hABCDEF);
        out_ready = 1'b1; audio_data = 24'hABCDEF; ready = 1'b1;
        step();
        ready = 1'b0; audio_data = '0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL single_valid_n1: got %b want 0", out_valid); end
        n_cmp++; if (fifo_count !== CW'(1)) begin n_bad++; $display("[TB] FAIL single_count_n1: got %0d want 1", fifo_count); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL single_valid_n2: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== exp_q[0]) begin n_bad++; $display("[TB] FAIL single_first_byte: got %h want %h", out_data, exp_q[0]); end
        wait_bytes(base, exp_q.size(), ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL single_timeout: got %0d bytes want %0d", mon_n - base, exp_q.size()); end
        repeat (3) step();
        n_cmp++; if (mon_n - base != exp_q.size()) begin n_bad++; $display("[TB] FAIL single_nbytes: got %0d want %0d", mon_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < mon_n; i++) begin
            n_cmp++;
            if (mon_data[base+i] !== exp_q[i] || mon_last[base+i] !== expl_q[i]) begin
                n_bad++; $display("[TB] FAIL single_byte%0d: got %h last %b want %h last %b", i, mon_data[base+i], mon_last[base+i], exp_q[i], expl_q[i]);
            end
        end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL single_count_end: got %0d want 0", fifo_count); end
    endtask

    task automatic test_held_strobe();
        int base;
        base = mon_n;
        exp_q.delete(); expl_q.delete();
        push_sample(24'h123456);
        out_ready = 1'b1; audio_data = 24'h123456; ready = 1'b1;
        repeat (5) step();
        ready = 1'b0;
        repeat (15) step();
        n_cmp++; if (mon_n - base != exp_q.size()) begin n_bad++; $display("[TB] FAIL held_nbytes: got %0d want %0d", mon_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < mon_n; i++) begin
            n_cmp++;
            if (mon_data[base+i] !== exp_q[i] || mon_last[base+i] !== expl_q[i]) begin
                n_bad++; $display("[TB] FAIL held_byte%0d: got %h last %b want %h last %b", i, mon_data[base+i], mon_last[base+i], exp_q[i], expl_q[i]);
            end
        end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL held_count_end: got %0d want 0", fifo_count); end
    endtask

    // Sample 1 is popped into the shift register while stalled, so 17 writes leave 16 queued
    // and the 18th write is the first one dropped.
    task automatic test_overflow();
        int base;
        bit ok;
        base = mon_n;
        exp_q.delete(); expl_q.delete();
        out_ready = 1'b0;
        for (int v = 1; v <= 17; v++) begin
            audio_data = 24'(v); ready = 1'b1;
            step();
            ready = 1'b0;
            step();
            push_sample(24'(v));
        end
        n_cmp++; if (fifo_count !== CW'(16)) begin n_bad++; $display("[TB] FAIL ovf_count_17: got %0d want 16", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_flag_17: got %b want 0", overflow); end
        audio_data = 24'd18; ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_flag_18: got %b want 1", overflow); end
        n_cmp++; if (fifo_count !== CW'(16)) begin n_bad++; $display("[TB] FAIL ovf_count_18: got %0d want 16", fifo_count); end
        audio_data = 24'd19; ready = 1'b1; clear_ovf = 1'b1;
        step();
        ready = 1'b0; clear_ovf = 1'b0;
        step();
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_set_wins: got %b want 1", overflow); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow); end
        out_ready = 1'b1;
        repeat (SPB - 1) step();
        audio_data = 24'd20; ready = 1'b1;
        step();
        ready = 1'b0;
        push_sample(24'd20);
        n_cmp++; if (fifo_count !== CW'(16)) begin n_bad++; $display("[TB] FAIL ovf_full_pop_count: got %0d want 16", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_full_pop_flag: got %b want 0", overflow); end
        wait_bytes(base, exp_q.size(), ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_timeout: got %0d bytes want %0d", mon_n - base, exp_q.size()); end
        repeat (5) step();
        n_cmp++; if (mon_n - base != exp_q.size()) begin n_bad++; $display("[TB] FAIL ovf_nbytes: got %0d want %0d", mon_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < mon_n; i++) begin
            n_cmp++;
            if (mon_data[base+i] !== exp_q[i] || mon_last[base+i] !== expl_q[i]) begin
                n_bad++; $display("[TB] FAIL ovf_byte%0d: got %h last %b want %h last %b", i, mon_data[base+i], mon_last[base+i], exp_q[i], expl_q[i]);
            end
        end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL ovf_count_end: got %0d want 0", fifo_count); end
    endtask

    task automatic test_backpressure();
        int base;
        int idx;
        bit ev;
        bit [0:7] pat = 8'b1001_0111;
        base = mon_n;
        exp_q.delete(); expl_q.delete();
        push_sample(24'h00FF80);
        out_ready = 1'b0; audio_data = 24'h00FF80; ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = pat[c];
            ev = (idx < exp_q.size());
            n_cmp++; if (out_valid !== ev) begin n_bad++; $display("[TB] FAIL bp_valid_c%0d: got %b want %b", c, out_valid, ev); end
            if (ev) begin
                n_cmp++;
                if (out_data !== exp_q[idx] || out_last !== expl_q[idx]) begin
                    n_bad++; $display("[TB] FAIL bp_data_c%0d: got %h last %b want %h last %b", c, out_data, out_last, exp_q[idx], expl_q[idx]);
                end
                if (pat[c]) idx++;
            end
            step();
        end
        out_ready = 1'b1;
        n_cmp++; if (mon_n - base != exp_q.size()) begin n_bad++; $display("[TB] FAIL bp_nbytes: got %0d want %0d", mon_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < mon_n; i++) begin
            n_cmp++;
            if (mon_data[base+i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL bp_byte%0d: got %h want %h", i, mon_data[base+i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_sample();
        int base;
        base = mon_n;
        exp_q.delete(); expl_q.delete();
        push_sample(24'h111111);
        out_ready = 1'b1; audio_data = 24'h111111; ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_bad++; $display("[TB] FAIL rst_first_byte: got %b/%h want 1/%h", out_valid, out_data, exp_q[0]); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_seq = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_out_data: got %h want 00", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_out_last: got %b want 0", out_last); end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_bad++; $display("[TB] FAIL rst_fifo_count: got %0d want 0", fifo_count); end
        repeat (10) step();
        n_cmp++; if (mon_n - base != 1) begin n_bad++; $display("[TB] FAIL rst_nbytes: got %0d want 1", mon_n - base); end
        n_cmp++; if (mon_data[base] !== exp_q[0]) begin n_bad++; $display("[TB] FAIL rst_byte0: got %h want %h", mon_data[base], exp_q[0]); end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = mon_n;
        exp_q.delete(); expl_q.delete();
        push_sample(24'h000001);
        push_sample(24'h000002);
        out_ready = 1'b1; audio_data = 24'h000001; ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        audio_data = 24'h000002; ready = 1'b1;
        step();
        ready = 1'b0;
        wait_bytes(base, exp_q.size(), ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_timeout: got %0d bytes want %0d", mon_n - base, exp_q.size()); end
        repeat (5) step();
        n_cmp++; if (mon_n - base != exp_q.size()) begin n_bad++; $display("[TB] FAIL b2b_nbytes: got %0d want %0d", mon_n - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < mon_n; i++) begin
            n_cmp++;
            if (mon_data[base+i] !== exp_q[i] || mon_last[base+i] !== expl_q[i]) begin
                n_bad++; $display("[TB] FAIL b2b_byte%0d: got %h last %b want %h last %b", i, mon_data[base+i], mon_last[base+i], exp_q[i], expl_q[i]);
            end
        end
        if (mon_n - base == 2 * SPB) begin
            n_cmp++;
            if (mon_cyc[base + 2*SPB - 1] - mon_cyc[base] != 2 * SPB - 1) begin
                n_bad++; $display("[TB] FAIL b2b_span: got %0d cycles want %0d", mon_cyc[base + 2*SPB - 1] - mon_cyc[base], 2 * SPB - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_strobe();
        test_overflow();
        test_backpressure();
        test_reset_mid_sample();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion want completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
